// File: rtl/alu_exec_unit.sv
// RV32I/M execute stage: single-cycle ALU ops plus iterative shift-add multiply and
// restoring divide, with valid/ready handshakes on both sides.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      func7,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
  } op_e;

  function automatic op_e base_op(input logic [2:0] f3, input logic arith);
    op_e op;
    case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = arith ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic op_e decode(input logic [1:0] aop, input logic [6:0] f7,
                                 input logic [2:0] f3);
    op_e op;
    op = OP_ILL;
    case (aop)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        if (f7 == 7'b0000000) begin
          op = base_op(f3, 1'b0);
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      op = OP_SUB;
          else if (f3 == 3'b101) op = OP_SRA;
        end else if (f7 == 7'b0000001 && ENABLE_M) begin
          case (f3)
            3'b000:  op = OP_MUL;
            3'b100:  op = OP_DIV;
            3'b101:  op = OP_DIVU;
            3'b110:  op = OP_REM;
            3'b111:  op = OP_REMU;
            default: op = OP_ILL;
          endcase
        end
      end
      default: begin
        // I-type: func7 is immediate bits except bit5 selecting SRAI
        op = base_op(f3, f7[5]);
        if (f3 == 3'b001 && f7 != 7'b0000000) op = OP_ILL;
      end
    endcase
    return op;
  endfunction

  function automatic logic [XLEN-1:0] alu_compute(input op_e op, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [SHW-1:0]         sh;
    logic [XLEN-1:0]        r;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLL:  r = a << sh;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, sa < sb};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:  r = a ^ b;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $unsigned(sa >>> sh);
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_e          state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  // opnd: multiplicand / divisor; shft: multiplier / dividend->quotient; acc: product / remainder
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] shft_q, shft_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic            sel_rem_q, sel_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;

  op_e             in_op;
  logic            in_div, in_signed, accept, busy_w, last_iter;
  logic [XLEN-1:0] sc_res, mul_acc_nx, rem_nx, quo_nx, div_res;
  logic [XLEN:0]   rem_sh, rem_diff;
  logic            div_ge;

  assign in_op     = decode(alu_op, func7, func3);
  assign in_div    = (in_op == OP_DIV) || (in_op == OP_DIVU) ||
                     (in_op == OP_REM) || (in_op == OP_REMU);
  assign in_signed = (in_op == OP_DIV) || (in_op == OP_REM);
  assign sc_res    = alu_compute(in_op, operand_a, operand_b);

  assign busy_w    = (state_q == S_MUL) || (state_q == S_DIV);
  assign in_ready  = ~busy_w & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt_q == SHW'(XLEN - 1));

  assign mul_acc_nx = acc_q + (shft_q[0] ? opnd_q : '0);

  // Borrow out of the trial subtraction tells whether the divisor fits
  assign rem_sh   = {acc_q, shft_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, opnd_q};
  assign div_ge   = ~rem_diff[XLEN];
  assign rem_nx   = div_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx   = {shft_q[XLEN-2:0], div_ge};
  assign div_res  = sel_rem_q ? apply_sign(rem_nx, neg_rem_q) : apply_sign(quo_nx, neg_quo_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    opnd_d      = opnd_q;
    shft_d      = shft_q;
    acc_d       = acc_q;
    sel_rem_d   = sel_rem_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    case (state_q)
      S_MUL: begin
        acc_d  = mul_acc_nx;
        opnd_d = opnd_q << 1;
        shft_d = shft_q >> 1;
        cnt_d  = cnt_q + SHW'(1);
        if (last_iter) begin
          state_d     = S_DONE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          result_d    = mul_acc_nx;
          zero_d      = (mul_acc_nx == '0);
          illegal_d   = 1'b0;
        end
      end
      S_DIV: begin
        acc_d  = rem_nx;
        shft_d = quo_nx;
        cnt_d  = cnt_q + SHW'(1);
        if (last_iter) begin
          state_d     = S_DONE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          result_d    = div_res;
          zero_d      = (div_res == '0);
          illegal_d   = 1'b0;
        end
      end
      default: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
        if (accept) begin
          cnt_d = '0;
          if (in_op == OP_MUL) begin
            state_d = S_MUL;
            opnd_d  = operand_a;
            shft_d  = operand_b;
            acc_d   = '0;
          end else if (in_div) begin
            state_d   = S_DIV;
            opnd_d    = magnitude(operand_b, in_signed);
            shft_d    = magnitude(operand_a, in_signed);
            acc_d     = '0;
            sel_rem_d = (in_op == OP_REM) || (in_op == OP_REMU);
            neg_rem_d = in_signed & operand_a[XLEN-1];
            // a zero divisor keeps the all-ones quotient unsigned
            neg_quo_d = in_signed & (operand_a[XLEN-1] ^ operand_b[XLEN-1]) & (|operand_b);
          end else begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            result_d    = sc_res;
            zero_d      = (sc_res == '0);
            illegal_d   = (in_op == OP_ILL);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  always_ff @(posedge clk) begin
    opnd_q    <= opnd_d;
    shft_q    <= shft_d;
    acc_q     <= acc_d;
    sel_rem_q <= sel_rem_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign busy      = busy_w;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised and directed bench for alu_exec_unit against a plain-arithmetic reference model.
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, in_valid, in_ready, out_valid, out_ready, zero, illegal, busy;
  logic [1:0]      alu_op;
  logic [6:0]      func7;
  logic [2:0]      func3;
  logic [XLEN-1:0] operand_a, operand_b, result;

  logic            n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_zero, n_illegal, n_busy;
  logic [1:0]      n_alu_op;
  logic [6:0]      n_func7;
  logic [2:0]      n_func3;
  logic [XLEN-1:0] n_a, n_b, n_result;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.XLEN(XLEN), .ENABLE_M(1'b1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .func7(func7), .func3(func3),
    .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal), .busy(busy));

  alu_exec_unit #(.XLEN(XLEN), .ENABLE_M(1'b0)) u_nom (
    .clk(clk), .reset(reset), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .alu_op(n_alu_op), .func7(n_func7), .func3(n_func3),
    .operand_a(n_a), .operand_b(n_b),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .result(n_result),
    .zero(n_zero), .illegal(n_illegal), .busy(n_busy));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what each instruction means arithmetically
  function automatic void ref_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input bit en_m, output logic [XLEN-1:0] r,
                                 output bit ill, output bit multi);
    longint sa, sb;
    int     sh;
    bit     isi;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    isi = (op == 2'b11);
    r = '0; ill = 1'b0; multi = 1'b0;
    if (op == 2'b00) r = a + b;
    else if (op == 2'b01) r = a - b;
    else if (!isi && f7 == 7'h01) begin
      if (!en_m) ill = 1'b1;
      else begin
        multi = 1'b1;
        case (f3)
          3'd0: r = a * b;
          3'd4: r = (b == 0) ? '1 : XLEN'(sa / sb);
          3'd5: r = (b == 0) ? '1 : a / b;
          3'd6: r = (b == 0) ? a : XLEN'(sa % sb);
          3'd7: r = (b == 0) ? a : a % b;
          default: begin ill = 1'b1; multi = 1'b0; end
        endcase
      end
    end else if (!isi && f7 == 7'h20) begin
      if (f3 == 3'd0) r = a - b;
      else if (f3 == 3'd5) r = XLEN'(sa >>> sh);
      else ill = 1'b1;
    end else if (!isi && f7 != 7'h00) ill = 1'b1;
    else begin
      case (f3)
        3'd0: r = a + b;
        3'd1: if (isi && f7 != 7'h00) ill = 1'b1; else r = a << sh;
        3'd2: r = (sa < sb) ? 1 : 0;
        3'd3: r = (a < b) ? 1 : 0;
        3'd4: r = a ^ b;
        3'd5: r = (isi && f7[5]) ? XLEN'(sa >>> sh) : a >> sh;
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
  endfunction

  task automatic do_op(input string tag, input logic [1:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       output logic [XLEN-1:0] res);
    logic [XLEN-1:0] er;
    bit eill, emul;
    int k, w;
    ref_op(op, f7, f3, a, b, 1'b1, er, eill, emul);
    @(negedge clk);
    alu_op = op; func7 = f7; func3 = f3; operand_a = a; operand_b = b; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; operand_a = $urandom; operand_b = $urandom; func3 = 3'($urandom);
    chk({tag, "_busy"}, busy, emul);
    k = 0;
    while (!out_valid && k < 200) begin @(posedge clk); #1; k++; end
    chk({tag, "_lat"}, k, emul ? XLEN : 0);
    chk({tag, "_res"}, result, er);
    chk({tag, "_zero"}, zero, er == '0);
    chk({tag, "_ill"}, illegal, eill);
    res = result;
  endtask

  function automatic logic [XLEN-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] got[$];
    logic [6:0] f7;
    bit seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; func7 = '0; func3 = '0; operand_a = '0; operand_b = '0;
    n_in_valid = 1'b0; n_out_ready = 1'b1; n_alu_op = '0; n_func7 = '0; n_func3 = '0;
    n_a = '0; n_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", in_ready, 1);
    @(negedge clk); reset = 1'b0;

    do_op("add", 2'b00, 7'h00, 3'd0, 32'd7, 32'hFFFF_FFFD, r);         chk("add_lit", r, 32'd4);
    do_op("sub", 2'b01, 7'h00, 3'd0, 32'd5, 32'd5, r);                 chk("sub_lit", r, 32'd0);
    chk("sub_zero_lit", zero, 1);
    do_op("sra", 2'b10, 7'h20, 3'd5, 32'h8000_0000, 32'd4, r);         chk("sra_lit", r, 32'hF800_0000);
    do_op("srai", 2'b11, 7'h20, 3'd5, 32'h8000_0000, 32'd4, r);        chk("srai_lit", r, 32'hF800_0000);
    do_op("sltu", 2'b10, 7'h00, 3'd3, 32'd1, 32'hFFFF_FFFF, r);        chk("sltu_lit", r, 32'd1);
    do_op("div", 2'b10, 7'h01, 3'd4, 32'hFFFF_FFF9, 32'd2, r);         chk("div_lit", r, 32'hFFFF_FFFD);
    do_op("rem", 2'b10, 7'h01, 3'd6, 32'hFFFF_FFF9, 32'd2, r);         chk("rem_lit", r, 32'hFFFF_FFFF);
    do_op("divu0", 2'b10, 7'h01, 3'd5, 32'd100, 32'd0, r);             chk("divu0_lit", r, 32'hFFFF_FFFF);
    do_op("rem0", 2'b10, 7'h01, 3'd6, 32'd100, 32'd0, r);              chk("rem0_lit", r, 32'd100);
    do_op("divov", 2'b10, 7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, r); chk("divov_lit", r, 32'h8000_0000);
    do_op("remov", 2'b10, 7'h01, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, r); chk("remov_lit", r, 32'd0);
    do_op("mul", 2'b10, 7'h01, 3'd0, 32'hFFFF_FFFF, 32'd3, r);         chk("mul_lit", r, 32'hFFFF_FFFD);
    do_op("mulh", 2'b10, 7'h01, 3'd1, 32'd9, 32'd9, r);                chk("mulh_ill", illegal, 1);
    do_op("slli_bad", 2'b11, 7'h01, 3'd1, 32'd9, 32'd1, r);            chk("slli_ill", illegal, 1);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    f7 = 7'h00;
        2:       f7 = 7'h20;
        3:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      do_op("rnd", 2'($urandom), f7, 3'($urandom), pick(), pick(), r);
    end

    // Output stall, then a back-to-back stream
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    alu_op = 2'b00; func7 = '0; func3 = '0; operand_a = 32'd1; operand_b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stall_vld0", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_res", result, 32'd3);
      chk("stall_vld", out_valid, 1);
      chk("stall_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          alu_op = 2'b00; operand_a = 32'(i * 7 + 1); operand_b = 32'(i * 3); in_valid = 1'b1;
          chk("strm_rdy", in_ready, 1);
        end
        @(negedge clk); in_valid = 1'b0;
      end
      begin
        repeat (16) begin
          @(negedge clk);
          if (out_valid && out_ready) got.push_back(result);
        end
      end
    join
    chk("strm_cnt", got.size(), 11);
    if (got.size() == 11) begin
      chk("strm_first", got[0], 32'd3);
      for (int i = 0; i < 10; i++) chk("strm_val", got[i+1], 32'(i * 10 + 1));
    end

    // Reset in the middle of a divide
    @(negedge clk);
    alu_op = 2'b10; func7 = 7'h01; func3 = 3'd4; operand_a = 32'd1000; operand_b = 32'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_vld", out_valid, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk("abort_nores", seen, 0);
    do_op("post_rst", 2'b11, 7'h00, 3'd6, 32'h0F0F_0000, 32'h0000_00F0, r);

    // M extension disabled
    @(negedge clk);
    n_alu_op = 2'b10; n_func7 = 7'h01; n_func3 = 3'd0; n_a = 32'd5; n_b = 32'd3; n_in_valid = 1'b1;
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    chk("nom_vld", n_out_valid, 1);
    chk("nom_ill", n_illegal, 1);
    chk("nom_res", n_result, 0);
    chk("nom_busy", n_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
